sort_arbiter: RTL and testbench
===============================

# sort_arbiter

Round-robin controller that shares a single `bitonic_top` sorter instance among `NUM_REQ` requesters. It accepts one sort job at a time over per-requester valid/ready handshakes and registers the operand vector. It then drives the sorter's `valid`/`data_in`, waits for `done` with a timeout guard, and returns the sorted vector to the granted requester. It sits between the sorter and the client blocks, one level above `bitonic_top`.

## Interface
- `NUM_REQ`, 4: number of requesters, ≥2.
- `NUM_INPUT`, 8: elements per sort job; must match the sorter.
- `DATA_WIDTH`, 8: bits per element; must match the sorter.
- `TIMEOUT`, 64: max WAIT cycles before a job is aborted; ≥2.
- Derived: `ALL_WIDTH = NUM_INPUT*DATA_WIDTH`, `ID_W = max(1,$clog2(NUM_REQ))`.

Ports:
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `req_valid` input NUM_REQ: job request per requester.
- `req_data` input NUM_REQ*ALL_WIDTH: operands; requester r occupies `[ALL_WIDTH*(r+1)-1 -: ALL_WIDTH]`.
- `req_ready` output NUM_REQ: one-hot accept strobe.
- `rsp_valid` output NUM_REQ: one-hot result valid.
- `rsp_ready` input NUM_REQ: result accept per requester.
- `rsp_data` output ALL_WIDTH: shared result bus.
- `rsp_err` output 1: result is a timeout abort; qualified by `rsp_valid`.
- `srt_data_in` output ALL_WIDTH: to sorter `data_in`.
- `srt_valid` output 1: to sorter `valid`.
- `srt_done` input 1: from sorter `done`.
- `srt_data_out` input ALL_WIDTH: from sorter `data_out`.
- `busy` output 1: high in any state other than IDLE.
- `grant_id` output ID_W: index of the current or last granted requester.

## Operation
- FSM states: IDLE, WAIT, RESP, FLUSH.
- **IDLE**
  - If any `req_valid` is high, pick the first asserted requester searching from `last+1` upward with wrap-around.
  - Assert `req_ready[g]` combinationally in the same cycle. That cycle is the handshake.
  - On the edge: latch `req_data` slice g into the operand register, set `grant_id=g` and `last=g`, clear the counter, go to WAIT.
- **WAIT**
  - `srt_valid=1`; `srt_data_in` = operand register, held stable.
  - If `srt_done`=1: capture `srt_data_out` into the result register, `rsp_err=0`, go to RESP.
  - Else if counter == TIMEOUT-1: result register = 0, `rsp_err=1`, go to RESP.
  - Else: counter increments.
  - `srt_done` has priority over timeout when both occur in the same cycle.
- **RESP**
  - `srt_valid=0`; `rsp_valid[grant_id]=1`; `rsp_data` = result register.
  - Hold until `rsp_ready[grant_id]`=1. `rsp_ready` from other requesters is ignored.
  - On acceptance, go to FLUSH.
- **FLUSH**
  - Wait until `srt_done`=0, then go to IDLE. If `srt_done` is already 0, this takes exactly 1 cycle.
  - Prevents a stale `done` from completing the next job.
- `req_ready` is zero outside IDLE, so requests stay pending.
- `req_valid` deasserting without a handshake is legal; no state change results.
- The sorter input is never driven with `srt_valid`=1 outside WAIT.

## Timing
- Reset (asynchronous, `reset`=0): state=IDLE; `last=NUM_REQ-1`, so requester 0 wins first; `grant_id=0`, counter=0, operand and result registers=0; `req_ready=0`, `rsp_valid=0`, `rsp_data=0`, `rsp_err=0`, `srt_valid=0`, `srt_data_in=0`, `busy=0`.
- Reset mid-job: abort immediately. No response is issued, and the requester must re-request.
- Latency:
  - Handshake edge T → `srt_valid` high from T+1.
  - `srt_done` sampled high at the edge ending WAIT cycle k → `rsp_valid` from the next cycle.
  - Zero-wait completion: `rsp_valid` at T+2.
- Timeout: with no `done`, `rsp_valid` with `rsp_err` rises TIMEOUT+1 cycles after the handshake edge.
- Throughput: at most one job per (sorter latency + 3) cycles when `rsp_ready` is held high and `done` drops promptly.
- Simultaneous requests: exactly one grant per IDLE cycle; strict rotation gives no starvation.
- A requester may re-request in the cycle right after its `rsp_valid` handshake. It does not win ahead of other pending requesters.

## Test plan
- Single job: `req_valid[0]` with data 0x0801070206030504, sorter returns sorted after 3 cycles → `req_ready[0]` for one cycle, `srt_valid` for 3 WAIT cycles, `rsp_valid[0]` with data 0x0807060504030201, `rsp_err=0`.
- Round robin: all 4 `req_valid` held high, `rsp_ready` tied high → grant order 0,1,2,3,0; each `req_ready` is one-hot and never asserted while `busy`.
- Backpressure: hold `rsp_ready[2]`=0 for 10 cycles → `rsp_valid[2]` and `rsp_data` stay stable; `req_ready` stays 0 for all requesters; release → FLUSH then IDLE.
- Timeout: TIMEOUT=8, `srt_done` stuck low → `rsp_valid` with `rsp_err=1` and `rsp_data=0`, 9 cycles after the handshake; with `done` and timeout in the same cycle, `rsp_err=0`.
- Stale done: `srt_done` held high 4 cycles past the response → FSM stays in FLUSH until it drops; the next job does not complete before `srt_done` has gone low and then high again.
- Reset mid-WAIT: assert `reset`=0 → all outputs are zero asynchronously; after release, requester 0 wins the first grant.

Source files
------------

// File: rtl/sort_arbiter.sv
// rtl/sort_arbiter.sv - round-robin controller sharing one bitonic sorter among several requesters
//
// Purpose: accepts one sort job at a time from NUM_REQ requesters (rotating
// priority), feeds the registered operand vector to the sorter, waits for
// done under a timeout guard, and returns the result to the granted requester.
//
// Ports:
//   clk, reset            clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready   per-requester job handshake (req_ready is one-hot)
//   req_data              packed operand vectors, requester r at slice r
//   rsp_valid/rsp_ready   per-requester result handshake (rsp_valid is one-hot)
//   rsp_data, rsp_err     shared result bus; rsp_err flags a timeout abort
//   srt_valid, srt_data_in, srt_done, srt_data_out   sorter interface
//   busy                  high whenever a job is in flight
//   grant_id              current or most recently granted requester

module sort_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int NUM_INPUT  = 8,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 64,
  localparam int ALL_WIDTH = NUM_INPUT * DATA_WIDTH,
  localparam int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*ALL_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [NUM_REQ-1:0]           rsp_valid,
  input  logic [NUM_REQ-1:0]           rsp_ready,
  output logic [ALL_WIDTH-1:0]         rsp_data,
  output logic                         rsp_err,
  output logic [ALL_WIDTH-1:0]         srt_data_in,
  output logic                         srt_valid,
  input  logic                         srt_done,
  input  logic [ALL_WIDTH-1:0]         srt_data_out,
  output logic                         busy,
  output logic [ID_W-1:0]              grant_id
);

  localparam int CNT_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, WAIT, RESP, FLUSH} state_t;

  state_t               state;
  state_t               state_nxt;
  logic [ID_W-1:0]      last;
  logic [ID_W-1:0]      pick;
  logic [ID_W-1:0]      cand;
  logic                 found;
  logic [CNT_W-1:0]     cnt;
  logic [ALL_WIDTH-1:0] operand;
  logic [ALL_WIDTH-1:0] result;
  logic                 err;
  logic                 timeout_hit;

  // Rotating priority: scan last+1, last+2, ... with wrap; the previous winner
  // is checked last, so a requester that re-requests cannot jump the queue.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = ID_W'((int'(last) + i) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));

  // req_ready is qualified by reset so every output reads zero while reset is held.
  always_comb begin
    req_ready = '0;
    if (reset && state == IDLE && found) req_ready[pick] = 1'b1;
  end

  always_comb begin
    rsp_valid = '0;
    if (state == RESP) rsp_valid[grant_id] = 1'b1;
  end

  assign srt_valid   = (state == WAIT);
  assign srt_data_in = operand;
  assign rsp_data    = (state == RESP) ? result : '0;
  assign rsp_err     = (state == RESP) && err;
  assign busy        = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // FLUSH waits for done to drop so a lingering done from this job cannot
  // complete the next one on its first WAIT cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = WAIT;
      WAIT:    if (srt_done || timeout_hit) state_nxt = RESP;
      RESP:    if (rsp_ready[grant_id]) state_nxt = FLUSH;
      FLUSH:   if (!srt_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last     <= ID_W'(NUM_REQ - 1);
      grant_id <= '0;
      cnt      <= '0;
      operand  <= '0;
      result   <= '0;
      err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            operand  <= req_data[ALL_WIDTH*int'(pick) +: ALL_WIDTH];
            grant_id <= pick;
            last     <= pick;
            cnt      <= '0;
          end
        end
        WAIT: begin
          // done wins over timeout when both land on the same cycle
          if (srt_done) begin
            result <= srt_data_out;
            err    <= 1'b0;
          end else if (timeout_hit) begin
            result <= '0;
            err    <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sort_arbiter.sv
// tb/tb_sort_arbiter.sv - self-checking bench for sort_arbiter with a stub sorter and a reference model

module tb_sort_arbiter;

  localparam int NR = 4;
  localparam int TO = 8;
  localparam int AW = 64;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [NR-1:0]   req_valid = '0;
  logic [NR*AW-1:0] req_data = '0;
  logic [NR-1:0]   req_ready;
  logic [NR-1:0]   rsp_valid;
  logic [NR-1:0]   rsp_ready = '1;
  logic [AW-1:0]   rsp_data;
  logic            rsp_err;
  logic [AW-1:0]   srt_data_in;
  logic            srt_valid;
  logic            srt_done = 1'b0;
  logic [AW-1:0]   srt_data_out = '0;
  logic            busy;
  logic [1:0]      grant_id;

  sort_arbiter #(.NUM_REQ(NR), .NUM_INPUT(8), .DATA_WIDTH(8), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .srt_data_in(srt_data_in), .srt_valid(srt_valid), .srt_done(srt_done),
    .srt_data_out(srt_data_out), .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int grants[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Ascending sort of eight bytes: smallest element lands in the low byte.
  function automatic logic [63:0] sort64(input logic [63:0] v);
    logic [7:0] e[8];
    logic [7:0] t;
    logic [63:0] r;
    for (int i = 0; i < 8; i++) e[i] = v[i*8 +: 8];
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 7 - i; j++)
        if (e[j] > e[j+1]) begin
          t = e[j]; e[j] = e[j+1]; e[j+1] = t;
        end
    r = '0;
    for (int i = 0; i < 8; i++) r[i*8 +: 8] = e[i];
    return r;
  endfunction

  // Stub sorter: raises done on the st_lat-th cycle of srt_valid (unless stuck),
  // optionally keeps done high for st_hold cycles after srt_valid falls.
  int st_lat = 3;
  bit st_stuck = 1'b0;
  int st_hold = 0;
  int vcnt = 0;
  int hold_left = 0;

  always @(posedge clk) begin
    #1;
    srt_data_out = sort64(srt_data_in);
    if (srt_valid) begin
      vcnt++;
      hold_left = st_hold;
      srt_done = !st_stuck && (vcnt >= st_lat);
    end else begin
      vcnt = 0;
      if (srt_done && hold_left > 0) hold_left--;
      else srt_done = 1'b0;
    end
  end

  // Reference model: 0 = no job, 1 = sorting, 2 = answering, 3 = draining stale done.
  int          m_phase = 0;
  int          m_last = NR - 1;
  int          m_gid = 0;
  int          m_age = 0;
  logic [63:0] m_oper = '0;
  logic [63:0] m_res = '0;
  bit          m_err = 1'b0;

  function automatic int pick_model();
    for (int i = 1; i <= NR; i++) begin
      int r;
      r = (m_last + i) % NR;
      if (req_valid[r]) return r;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_phase = 0; m_last = NR - 1; m_gid = 0; m_age = 0;
      m_oper = '0; m_res = '0; m_err = 1'b0;
    end else begin
      case (m_phase)
        0: begin
          int g;
          g = pick_model();
          if (g >= 0) begin
            m_oper = req_data[g*AW +: AW];
            m_gid = g; m_last = g; m_age = 0; m_phase = 1;
          end
        end
        1: begin
          m_age++;
          if (srt_done) begin
            m_res = sort64(m_oper); m_err = 1'b0; m_phase = 2;
          end else if (m_age >= TO) begin
            m_res = '0; m_err = 1'b1; m_phase = 2;
          end
        end
        2: if (rsp_ready[m_gid]) m_phase = 3;
        default: if (!srt_done) m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    int g;
    logic [63:0] er;
    g = pick_model();
    er = (reset && m_phase == 0 && g >= 0) ? (64'd1 << g) : 64'd0;
    chk("req_ready", req_ready, er);
    chk("busy", busy, m_phase != 0);
    chk("srt_valid", srt_valid, m_phase == 1);
    chk("srt_data_in", srt_data_in, m_oper);
    chk("rsp_valid", rsp_valid, (m_phase == 2) ? (64'd1 << m_gid) : 64'd0);
    chk("rsp_data", rsp_data, (m_phase == 2) ? m_res : 64'd0);
    chk("rsp_err", rsp_err, (m_phase == 2) && m_err);
    chk("grant_id", grant_id, m_gid);
    for (int r = 0; r < NR; r++) if (req_ready[r]) grants.push_back(r);
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string nm);
    int k;
    k = 0;
    while (busy && k < 300) begin cyc(1); k++; end
    chk({nm, "_idle_bound"}, busy, 1'b0);
  endtask

  // Issue one job from requester r (DUT must be idle); returns at the first RESP cycle.
  task automatic run_job(input int r, input logic [63:0] d, input int exp_n, input int exp_nv,
                         input bit exp_err, input logic [63:0] exp_data, input string nm);
    int n, nv;
    req_data[r*AW +: AW] = d;
    req_valid = 4'(1 << r);
    #1;
    chk({nm, "_req_ready"}, req_ready, 64'd1 << r);
    @(posedge clk); #1;
    req_valid = '0;
    n = 1; nv = 0;
    while (!rsp_valid[r] && n < 100) begin
      if (srt_valid) nv++;
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_rsp_latency"}, n, exp_n);
    chk({nm, "_wait_cycles"}, nv, exp_nv);
    chk({nm, "_rsp_err"}, rsp_err, exp_err);
    chk({nm, "_rsp_data"}, rsp_data, exp_data);
  endtask

  initial begin
    int exp_rr[5] = '{0, 1, 2, 3, 0};
    int k, n;
    logic [63:0] d, saved;

    #2 reset = 1'b0;
    cyc(2);
    chk("rst_busy", busy, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_srt_valid", srt_valid, 0);
    chk("rst_srt_data_in", srt_data_in, 0);
    reset = 1'b1;
    cyc(1);

    // round robin with all requesters pending
    grants.delete();
    for (int r = 0; r < NR; r++) req_data[r*AW +: AW] = {$urandom, $urandom};
    st_lat = 2;
    req_valid = 4'hF;
    k = 0;
    while (grants.size() < 5 && k < 200) begin cyc(1); k++; end
    req_valid = '0;
    chk("rr_bound", k < 200, 1);
    for (int i = 0; i < 5; i++)
      chk($sformatf("rr_grant_%0d", i), (grants.size() > i) ? grants[i] : -1, exp_rr[i]);
    wait_idle("rr");

    // single job, sorter answers on the third WAIT cycle
    st_lat = 3;
    run_job(0, 64'h0801070206030504, 4, 3, 0, 64'h0807060504030201, "single");
    wait_idle("single");

    // zero-wait completion
    st_lat = 1; d = {$urandom, $urandom};
    run_job(2, d, 2, 1, 0, sort64(d), "zero_wait");
    wait_idle("zero_wait");

    // timeout with done stuck low
    st_stuck = 1'b1;
    run_job(1, {$urandom, $urandom}, TO + 1, TO, 1, 64'd0, "timeout");
    wait_idle("timeout");
    st_stuck = 1'b0;

    // done on the same cycle the timeout would fire
    st_lat = TO; d = {$urandom, $urandom};
    run_job(3, d, TO + 1, TO, 0, sort64(d), "done_at_timeout");
    wait_idle("done_at_timeout");

    // backpressure on requester 2; other rsp_ready bits must be ignored
    st_lat = 2;
    rsp_ready = 4'b1011;
    req_data[2*AW +: AW] = {$urandom, $urandom};
    req_valid = 4'b0100;
    k = 0;
    while (!rsp_valid[2] && k < 50) begin cyc(1); k++; end
    chk("bp_bound", k < 50, 1);
    saved = rsp_data;
    req_valid = 4'b1011;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("bp_rsp_valid", rsp_valid, 4'b0100);
      chk("bp_rsp_data", rsp_data, saved);
      chk("bp_req_ready", req_ready, 0);
      cyc(1);
    end
    rsp_ready = 4'hF;
    cyc(1);
    chk("bp_flush_busy", busy, 1);
    chk("bp_flush_rsp_valid", rsp_valid, 0);
    cyc(1);
    chk("bp_idle_busy", busy, 0);
    chk("bp_next_grant", req_ready, 4'b1000);
    req_valid = '0;
    cyc(2);
    chk("bp_withdraw_busy", busy, 0);

    // stale done held 4 cycles past the response
    st_lat = 2; st_hold = 4; d = {$urandom, $urandom};
    run_job(0, d, 3, 2, 0, sort64(d), "stale");
    req_data[1*AW +: AW] = {$urandom, $urandom};
    req_valid = 4'b0010;
    n = 0;
    while (busy && n < 20) begin cyc(1); n++; end
    chk("stale_flush_len", n, 5);
    #1;
    chk("stale_next_grant", req_ready, 4'b0010);
    st_hold = 0;
    cyc(1);
    req_valid = '0;
    wait_idle("stale");

    // reset in the middle of WAIT
    st_stuck = 1'b1;
    req_valid = 4'b0100;
    k = 0;
    while (!busy && k < 20) begin cyc(1); k++; end
    req_valid = '0;
    cyc(2);
    #2;
    reset = 1'b0;
    req_valid = 4'b1001;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_srt_valid", srt_valid, 0);
    chk("mid_rst_req_ready", req_ready, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_srt_data_in", srt_data_in, 0);
    chk("mid_rst_grant_id", grant_id, 0);
    cyc(2);
    st_stuck = 1'b0;
    reset = 1'b1;
    #1;
    chk("post_rst_first_grant", req_ready, 4'b0001);
    cyc(1);
    req_valid = '0;
    wait_idle("post_rst");

    // randomized traffic, checked cycle by cycle against the model
    for (int c = 0; c < 600; c++) begin
      req_valid = 4'($urandom & $urandom);
      for (int r = 0; r < NR; r++) req_data[r*AW +: AW] = {$urandom, $urandom};
      rsp_ready = 4'($urandom | $urandom);
      st_lat = $urandom_range(1, 10);
      st_stuck = ($urandom_range(0, 15) == 0);
      st_hold = $urandom_range(0, 3);
      if (c == 300) reset = 1'b0;
      if (c == 302) reset = 1'b1;
      cyc(1);
    end
    req_valid = '0;
    rsp_ready = 4'hF;
    st_stuck = 1'b0;
    st_hold = 0;
    wait_idle("random");
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
